mii_tx_nibble_mux: RTL and testbench
====================================

Name: mii_tx_nibble_mux

Overview:
- Byte-to-nibble transmit adapter for the 10/100 Mb/s path of the tri-mode MAC.
- The MAC core presents bytes at half the MII clock rate through a valid/ready handshake; this block serialises each byte onto MII TXD[3:0], low nibble first.
- Also covers preamble-independent framing, underrun abort, and minimum inter-frame gap.
- Sits between the MAC transmit engine and the MII output pads, clocked by the MII transmit clock.

Parameters:
- IFG_BYTES, 12, minimum idle gap in byte times; gap lasts 2*IFG_BYTES clk cycles with tx_en low.
- ABORT_NIBBLES, 2, nibble cycles of tx_en=1/tx_er=1 driven on underrun.

Ports:
- clk  in  1  MII transmit clock (2.5/25 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  byte valid from MAC core.
- s_data  in  8  byte to transmit.
- s_er  in  1  byte carries error; both nibbles sent with tx_er=1.
- s_last  in  1  final byte of frame.
- s_ready  out  1  block accepts byte when s_valid&s_ready at clk edge.
- mii_txd  out  4  MII transmit nibble, registered.
- mii_tx_en  out  1  MII transmit enable, registered.
- mii_tx_er  out  1  MII transmit error, registered.
- underrun  out  1  one-cycle pulse when a frame is aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): mii_txd=0, mii_tx_en=0, mii_tx_er=0, underrun=0, busy=0, s_ready=0; hold register empty; state IDLE; IFG counter 0, so there is no gap after reset. s_ready rises on the first edge after release. Reset mid-frame truncates the frame immediately, with no tx_er.
- Hold register: h_data, h_er, h_last, h_vld.
  - s_ready = !h_vld, except in DISCARD where s_ready=1.
  - Accept writes h and sets h_vld.
  - Move to cur (cur_data, cur_er, cur_last) clears h_vld.
- States: IDLE, HI, IFG, ABORT, DISCARD. "Emit LO" is the IDLE->HI or HI->HI transition.
- IDLE:
  - If h_vld, move h to cur and drive txd=h_data[3:0], tx_en=1, tx_er=h_er; go HI.
  - Otherwise drive tx_en=0, tx_er=0, txd=0.
- HI:
  - Drive txd=cur_data[7:4], tx_en=1, tx_er=cur_er.
  - Next cycle:
    - If cur_last, go IFG with counter=2*IFG_BYTES (drive tx_en=0).
    - Else if h_vld, emit LO of h and stay HI.
    - Else underrun: go ABORT with counter=ABORT_NIBBLES, pulse underrun.
  - If cur_last and h_vld both hold, go IFG; h is retained.
- Latency: byte accepted at edge E0 -> low nibble on pins after E1, high nibble after E2. s_ready is high again after E1. The next byte of the same frame must be accepted by E2 at the latest, or underrun occurs at E3. A source supplying one byte every 2 cycles therefore sustains line rate with no gaps.
- ABORT:
  - Drive txd=0, tx_en=1, tx_er=1 for ABORT_NIBBLES cycles.
  - Then go DISCARD, or go straight to IFG if the byte that ended the frame (s_last) was already seen in h.
- DISCARD: s_ready=1; accepted bytes are dropped; outputs idle. On accepting a byte with s_last, go IFG.
- IFG: outputs idle; counter decrements each cycle; h may fill. When counter reaches 1, go IDLE. This yields exactly 2*IFG_BYTES idle cycles between the last HI nibble and the next LO nibble.
- Single-byte frame (s_last on first byte): LO, HI, then IFG.
- s_er on any byte affects only that byte's two nibbles.

Decomposition:
- Shared package mii_tx_pkg: state enum (IDLE, HI, IFG, ABORT, DISCARD), default IFG_BYTES, and counter width of clog2(2*IFG_BYTES+1).
- No sub-module. The hold register and FSM are in one file, with a single output register stage.

Test Plan:
- Single frame, bytes 0x55,0xD5,0xA3 (last), source streaming every 2 cycles -> txd 5,5,5,D,3,A; tx_en high 6 cycles contiguous; tx_er 0; underrun 0.
- Back-to-back frames, two 4-byte frames, IFG_BYTES=12 -> exactly 24 cycles tx_en=0 between frames; 2nd frame's first byte held in h, s_ready low during gap.
- Underrun: frame 0x11,0x22, s_valid withheld after 2nd byte (no last) -> after nibble 2 of 0x22, txd=0 with tx_en=1 and tx_er=1 for 2 cycles; underrun pulses once; subsequent bytes dropped until s_last; then 24-cycle gap.
- Error byte: 0xF0 with s_er=1 mid-frame -> both nibbles (0,F) have tx_er=1; adjacent nibbles tx_er=0.
- Reset mid-frame: deassert reset_n during the HI nibble of byte 3 -> all outputs 0 asynchronously; after release, a new frame starts LO nibble with no IFG.
- Simultaneous: s_last byte in HI while next frame byte in h -> IFG entered; h preserved and transmitted as first byte after gap.

Source files
------------

// File: rtl/mii_tx_nibble_mux_pkg.sv
// Shared definitions for the MII byte-to-nibble transmit adapter:
// FSM state encodings, default timing parameters and counter sizing.
package mii_tx_pkg;

    localparam int IFG_BYTES_DEF     = 12;
    localparam int ABORT_NIBBLES_DEF = 2;
    localparam int CNT_W_DEF         = $clog2(2 * IFG_BYTES_DEF + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HI      = 3'd1;
    localparam logic [2:0] ST_IFG     = 3'd2;
    localparam logic [2:0] ST_ABORT   = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    // The shared counter holds either the gap length or the abort length.
    function automatic int cnt_width(input int ifg_bytes, input int abort_nibbles);
        int span;
        span = (abort_nibbles > 2 * ifg_bytes) ? abort_nibbles : 2 * ifg_bytes;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/mii_tx_nibble_mux_if.sv
// Byte stream handshake from the MAC transmit engine into the nibble mux.
interface mii_tx_nibble_mux_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_er;
    logic       s_last;
    logic       s_ready;

    modport master (output s_valid, s_data, s_er, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_er, s_last, output s_ready);
endinterface

// File: rtl/mii_tx_nibble_mux.sv
// Serialises MAC bytes onto MII TXD low nibble first, with underrun abort,
// discard of the remainder of an aborted frame, and minimum inter-frame gap.
module mii_tx_nibble_mux
    import mii_tx_pkg::*;
#(
    parameter int IFG_BYTES     = IFG_BYTES_DEF,
    parameter int ABORT_NIBBLES = ABORT_NIBBLES_DEF
)(
    input  logic                 clk,
    input  logic                 reset_n,
    mii_tx_nibble_mux_if.slave   s,
    output logic [3:0]           mii_txd,
    output logic                 mii_tx_en,
    output logic                 mii_tx_er,
    output logic                 underrun,
    output logic                 busy
);

    localparam int               CNT_W      = cnt_width(IFG_BYTES, ABORT_NIBBLES);
    localparam logic [CNT_W-1:0] IFG_LOAD   = CNT_W'(2 * IFG_BYTES);
    localparam logic [CNT_W-1:0] ABORT_LOAD = CNT_W'(ABORT_NIBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);

    logic [2:0]       state_r, state_s;
    logic             hi_done_r, hi_done_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       h_data_r, h_data_s;
    logic             h_er_r, h_er_s;
    logic             h_last_r, h_last_s;
    logic             h_vld_r, h_vld_s;
    logic [3:0]       cur_hi_r, cur_hi_s;
    logic             cur_er_r, cur_er_s;
    logic             cur_last_r, cur_last_s;
    logic [3:0]       txd_r, txd_s;
    logic             tx_en_r, tx_en_s;
    logic             tx_er_r, tx_er_s;
    logic             underrun_r, underrun_s;
    logic             busy_r, busy_s;
    logic             s_ready_r, s_ready_s;
    logic             accept_s;

    assign s.s_ready = s_ready_r;
    assign mii_txd   = txd_r;
    assign mii_tx_en = tx_en_r;
    assign mii_tx_er = tx_er_r;
    assign underrun  = underrun_r;
    assign busy      = busy_r;

    // Next-state, hold register, current byte and pin values for the coming edge.
    always_comb begin
        state_s    = state_r;
        hi_done_s  = hi_done_r;
        cnt_s      = cnt_r;
        h_data_s   = h_data_r;
        h_er_s     = h_er_r;
        h_last_s   = h_last_r;
        h_vld_s    = h_vld_r;
        cur_hi_s   = cur_hi_r;
        cur_er_s   = cur_er_r;
        cur_last_s = cur_last_r;
        txd_s      = 4'h0;
        tx_en_s    = 1'b0;
        tx_er_s    = 1'b0;
        underrun_s = 1'b0;
        accept_s   = s.s_valid & s_ready_r;

        if (accept_s && (state_r != ST_DISCARD)) begin
            h_data_s = s.s_data;
            h_er_s   = s.s_er;
            h_last_s = s.s_last;
            h_vld_s  = 1'b1;
        end else begin
            h_vld_s  = h_vld_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (h_vld_r) begin
                    cur_hi_s   = h_data_r[7:4];
                    cur_er_s   = h_er_r;
                    cur_last_s = h_last_r;
                    h_vld_s    = 1'b0;
                    txd_s      = h_data_r[3:0];
                    tx_en_s    = 1'b1;
                    tx_er_s    = h_er_r;
                    hi_done_s  = 1'b0;
                    state_s    = ST_HI;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_HI: begin
                // hi_done_r marks that the high nibble is already on the pins.
                if (!hi_done_r) begin
                    txd_s      = cur_hi_r;
                    tx_en_s    = 1'b1;
                    tx_er_s    = cur_er_r;
                    hi_done_s  = 1'b1;
                end else if (cur_last_r) begin
                    cnt_s      = IFG_LOAD;
                    state_s    = ST_IFG;
                end else if (h_vld_r) begin
                    cur_hi_s   = h_data_r[7:4];
                    cur_er_s   = h_er_r;
                    cur_last_s = h_last_r;
                    h_vld_s    = 1'b0;
                    txd_s      = h_data_r[3:0];
                    tx_en_s    = 1'b1;
                    tx_er_s    = h_er_r;
                    hi_done_s  = 1'b0;
                end else begin
                    cnt_s      = ABORT_LOAD;
                    underrun_s = 1'b1;
                    tx_en_s    = 1'b1;
                    tx_er_s    = 1'b1;
                    state_s    = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (cnt_r > CNT_ONE) begin
                    cnt_s   = cnt_r - CNT_ONE;
                    tx_en_s = 1'b1;
                    tx_er_s = 1'b1;
                end else begin
                    // Anything held belongs to the aborted frame and is dropped.
                    h_vld_s = 1'b0;
                    if ((h_vld_r && h_last_r) || (accept_s && s.s_last)) begin
                        cnt_s   = IFG_LOAD;
                        state_s = ST_IFG;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (accept_s && s.s_last) begin
                    cnt_s   = IFG_LOAD;
                    state_s = ST_IFG;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            ST_IFG: begin
                // Leaving at 2 lets IDLE emit on the next edge, giving exactly 2*IFG_BYTES idle cycles.
                if (cnt_r <= CNT_TWO) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                h_vld_s = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        s_ready_s = (state_s == ST_DISCARD) || !h_vld_s;
        busy_s    = (state_s != ST_IDLE);
    end

    // State, hold/current byte storage and the single registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            hi_done_r  <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            h_data_r   <= 8'h00;
            h_er_r     <= 1'b0;
            h_last_r   <= 1'b0;
            h_vld_r    <= 1'b0;
            cur_hi_r   <= 4'h0;
            cur_er_r   <= 1'b0;
            cur_last_r <= 1'b0;
            txd_r      <= 4'h0;
            tx_en_r    <= 1'b0;
            tx_er_r    <= 1'b0;
            underrun_r <= 1'b0;
            busy_r     <= 1'b0;
            s_ready_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            hi_done_r  <= hi_done_s;
            cnt_r      <= cnt_s;
            h_data_r   <= h_data_s;
            h_er_r     <= h_er_s;
            h_last_r   <= h_last_s;
            h_vld_r    <= h_vld_s;
            cur_hi_r   <= cur_hi_s;
            cur_er_r   <= cur_er_s;
            cur_last_r <= cur_last_s;
            txd_r      <= txd_s;
            tx_en_r    <= tx_en_s;
            tx_er_r    <= tx_er_s;
            underrun_r <= underrun_s;
            busy_r     <= busy_s;
            s_ready_r  <= s_ready_s;
        end
    end

endmodule

// File: tb/tb_mii_tx_nibble_mux.sv
// Directed bench for mii_tx_nibble_mux: per-cycle vector tables plus
// hand-written sequences for gap length, back-to-back frames and mid-frame reset.
module tb_mii_tx_nibble_mux;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       e;
        logic       l;
        logic [3:0] txd;
        logic       en;
        logic       er;
        logic       ur;
        logic       rdy;
        logic       bsy;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic       mii_tx_er;
    logic       underrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    vec_t       tbl[$];
    logic [7:0] mon_q[$];
    logic       mon_on = 1'b0;

    mii_tx_nibble_mux_if sif ();

    mii_tx_nibble_mux dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s         (sif),
        .mii_txd   (mii_txd),
        .mii_tx_en (mii_tx_en),
        .mii_tx_er (mii_tx_er),
        .underrun  (underrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_on) mon_q.push_back({sif.s_ready, underrun, mii_tx_er, mii_tx_en, mii_txd});
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d, input logic e,
                                input logic l, input logic [3:0] txd, input logic en, input logic er,
                                input logic ur, input logic rdy, input logic bsy);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.e = e; r.l = l;
        r.txd = txd; r.en = en; r.er = er; r.ur = ur; r.rdy = rdy; r.bsy = bsy;
        return r;
    endfunction

    function automatic logic [8:0] outs();
        return {mii_txd, mii_tx_en, mii_tx_er, underrun, sif.s_ready, busy};
    endfunction

    task automatic do_reset();
        sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_er = 1'b0; sif.s_last = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Offers one byte and returns at the negedge after the edge that accepted it.
    task automatic send_byte(input logic [7:0] d, input logic l, input logic e);
        logic acc;
        acc = 1'b0;
        sif.s_valid = 1'b1; sif.s_data = d; sif.s_last = l; sif.s_er = e;
        for (int t = 0; t < 200; t++) begin
            acc = sif.s_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
        end
        sif.s_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0] exp1 [8];
        logic [3:0] exp2 [8];
        int i0;
        int gap;
        int bad;
        int idle;
        logic rdy_in_gap;

        // --- reset state ---
        sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_er = 1'b0; sif.s_last = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(outs()), 32'd0);

        // --- vector tables: {rst,v,d,e,l | txd,en,er,ur,rdy,bsy} ---
        // Frame 55 D5 A3(last), streaming
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'hD5, 0, 0, 4'h5, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'hA3, 0, 1, 4'hD, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h3, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hA, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        // Frame 12 F0(er) 34(last)
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'hF0, 1, 0, 4'h1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'h34, 0, 1, 4'hF, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h4, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h3, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        // Underrun after 11 22, then 33 44 dropped, 55(last) ends discard
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 4'h1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h2, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 4'h0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 4'h0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 8'h55, 0, 1, 4'h0, 0, 0, 0, 1, 1));

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            sif.s_valid = tbl[k].v; sif.s_data = tbl[k].d; sif.s_er = tbl[k].e; sif.s_last = tbl[k].l;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", k), 32'(outs()),
                32'({tbl[k].txd, tbl[k].en, tbl[k].er, tbl[k].ur, tbl[k].rdy, tbl[k].bsy}));
        end

        // --- gap after discard: the idle sample just taken is the first gap cycle ---
        idle = 1;
        sif.s_valid = 1'b1; sif.s_data = 8'h66; sif.s_last = 1'b1; sif.s_er = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            @(negedge clk);
            sif.s_valid = 1'b0;
            if (mii_tx_en) break;
            idle++;
        end
        chk("discard_gap_len", 32'(idle), 32'd24);
        chk("post_gap_lo", 32'(mii_txd), 32'h6);

        // --- back-to-back 4-byte frames; second frame's first byte waits in h ---
        do_reset();
        mon_q.delete();
        mon_on = 1'b1;
        for (int b = 1; b <= 4; b++) send_byte(8'(b), (b == 4), 1'b0);
        for (int b = 1; b <= 4; b++) send_byte(8'(8'hA0 + b), (b == 4), 1'b0);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("b2b_drain", 32'(busy), 32'd0);
        mon_on = 1'b0;

        exp1 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};
        exp2 = '{4'h1, 4'hA, 4'h2, 4'hA, 4'h3, 4'hA, 4'h4, 4'hA};
        i0 = -1;
        foreach (mon_q[k]) if (i0 < 0 && mon_q[k][4]) i0 = k;
        if (i0 < 0 || i0 + 40 > mon_q.size()) begin
            chk("b2b_capture", 32'(mon_q.size()), 32'(i0 + 40));
        end else begin
            bad = 0;
            for (int k = 0; k < 8; k++) if (mon_q[i0+k][4:0] !== {1'b1, exp1[k]}) bad++;
            chk("b2b_frame1", 32'(bad), 32'd0);
            gap = 0;
            rdy_in_gap = 1'b0;
            for (int k = i0 + 8; k < mon_q.size() && !mon_q[k][4]; k++) begin
                gap++;
                rdy_in_gap = rdy_in_gap | mon_q[k][7];
            end
            chk("b2b_gap_len", 32'(gap), 32'd24);
            chk("b2b_ready_in_gap", 32'(rdy_in_gap), 32'd0);
            bad = 0;
            for (int k = 0; k < 8; k++)
                if (i0 + 8 + gap + k >= mon_q.size() || mon_q[i0+8+gap+k][4:0] !== {1'b1, exp2[k]}) bad++;
            chk("b2b_frame2", 32'(bad), 32'd0);
            bad = 0;
            foreach (mon_q[k]) if (mon_q[k][5] || mon_q[k][6]) bad++;
            chk("b2b_no_er_ur", 32'(bad), 32'd0);
        end

        // --- reset during the high nibble of the third byte ---
        do_reset();
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h30, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_hi", 32'({mii_txd, mii_tx_en}), 32'({4'h3, 1'b1}));
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h77, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_lo", 32'({mii_txd, mii_tx_en, mii_tx_er}), 32'({4'h7, 1'b1, 1'b0}));
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_hi", 32'({mii_txd, mii_tx_en, mii_tx_er}), 32'({4'h7, 1'b1, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
